// File: rtl/keypad_hit_scanner.sv
// 4x4 keypad scanner: sync, frame debounce, one-hot hit pulse.
// Optional KEY_GHOST_REJECT_EN: multi-key frames are ignored.
module keypad_hit_scanner #(
  parameter int ROW_DWELL       = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int HIT_LEN         = 16
) (
  input  logic        Clk,
  input  logic        Set,
  input  logic        Scan_en,
  input  logic [3:0]  Col_in,
  output logic [3:0]  Row_out,
  output logic [15:0] Hit_point,
  output logic        Key_valid,
  output logic [3:0]  Key_code
);

  localparam int DW = $clog2(ROW_DWELL);
  localparam logic [DW-1:0] LAST = DW'(ROW_DWELL - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0] HLEN = 8'(HIT_LEN);

  typedef enum logic [1:0] {IDLE, DRIVE, FRAME_END} scan_t;
  typedef enum logic {RELEASED, PRESSED} key_t;

  scan_t         state;
  key_t          key;
  key_t          key_nxt;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [1:0]    row;
  logic [DW-1:0] dwell;
  logic [15:0]   raw;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          prev_empty;
  logic [3:0]    prev_cand;
  logic [7:0]    hit_cnt;
  logic [3:0]    cand;
  logic          empty;
  logic          same;
  logic          fire;
  logic          frame_ok;

`ifdef KEY_GHOST_REJECT_EN
  assign frame_ok = ~|(raw & (raw - 16'd1));
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    cand = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (raw[i]) cand = 4'(i);
    empty = (raw == 16'd0);
    same = (cnt != 4'd0) && (prev_empty == empty) &&
           (empty || (prev_cand == cand));
    cnt_nxt = same ? ((cnt == DEB) ? cnt : cnt + 4'd1) : 4'd1;
    key_nxt = key;
    fire = 1'b0;
    if (!frame_ok) begin
      cnt_nxt = 4'd0;
    end else if (cnt_nxt == DEB) begin
      if (key == RELEASED && !empty) begin
        key_nxt = PRESSED;
        fire = 1'b1;
      end else if (key == PRESSED && empty) begin
        key_nxt = RELEASED;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Set) begin
      state      <= IDLE;
      key        <= RELEASED;
      sync1      <= 4'hF;
      sync2      <= 4'hF;
      row        <= 2'd0;
      dwell      <= '0;
      raw        <= 16'd0;
      cnt        <= 4'd0;
      prev_empty <= 1'b1;
      prev_cand  <= 4'd0;
      hit_cnt    <= 8'd0;
      Row_out    <= 4'hF;
      Hit_point  <= 16'd0;
      Key_valid  <= 1'b0;
      Key_code   <= 4'd0;
    end else begin
      sync1 <= Col_in;
      sync2 <= sync1;
      if (!Scan_en) begin
        state     <= IDLE;
        key       <= RELEASED;
        row       <= 2'd0;
        dwell     <= '0;
        cnt       <= 4'd0;
        hit_cnt   <= 8'd0;
        Row_out   <= 4'hF;
        Hit_point <= 16'd0;
        Key_valid <= 1'b0;
      end else begin
        Key_valid <= 1'b0;
        if (hit_cnt != 8'd0) begin
          hit_cnt <= hit_cnt - 8'd1;
          if (hit_cnt == 8'd1) Hit_point <= 16'd0;
        end
        unique case (state)
          IDLE: begin
            state   <= DRIVE;
            row     <= 2'd0;
            dwell   <= '0;
            Row_out <= 4'b1110;
          end
          DRIVE: begin
            if (dwell == LAST) begin
              raw[{row, 2'b00} +: 4] <= ~sync2;
              dwell <= '0;
              if (row == 2'd3) begin
                state   <= FRAME_END;
                Row_out <= 4'hF;
              end else begin
                row     <= row + 2'd1;
                Row_out <= ~(4'b0001 << (row + 2'd1));
              end
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
          FRAME_END: begin
            state   <= DRIVE;
            row     <= 2'd0;
            Row_out <= 4'b1110;
            cnt     <= cnt_nxt;
            key     <= key_nxt;
            if (frame_ok) begin
              prev_empty <= empty;
              prev_cand  <= cand;
            end
            // a new press restarts the pulse, so it stays one-hot
            if (fire) begin
              Hit_point <= 16'd1 << cand;
              hit_cnt   <= HLEN;
              Key_valid <= 1'b1;
              Key_code  <= cand;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
